// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU command front end:
//   - ALU input-select encodings {persist, load, reset}
//   - one-hot operation select constants
//   - sequencer state enum
//   - one-hot classifier used to reject multi-hot operation selects
// -----------------------------------------------------------------------------
package alu_pkg;

  // ALU in_sel encodings, bit order {persist, load, reset}
  localparam logic [2:0] INSEL_HOLD    = 3'b000;
  localparam logic [2:0] INSEL_RESET   = 3'b001;
  localparam logic [2:0] INSEL_LOAD    = 3'b010;
  localparam logic [2:0] INSEL_PERSIST = 3'b100;

  // One-hot operation selects; the all-zero select means CLEAR
  localparam logic [5:0] OP_CLEAR = 6'b000000;
  localparam logic [5:0] OP_ADD   = 6'b000001;
  localparam logic [5:0] OP_SUB   = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b000100;
  localparam logic [5:0] OP_OR    = 6'b001000;
  localparam logic [5:0] OP_XOR   = 6'b010000;
  localparam logic [5:0] OP_NOT   = 6'b100000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OH_ZERO  = 2'd0,
    OH_ONE   = 2'd1,
    OH_MULTI = 2'd2
  } onehot_t;

  // Classify a select vector (zero-extended to 32 bits). Clearing the lowest
  // set bit leaves zero exactly when at most one bit was set.
  function automatic onehot_t onehot_class(input logic [31:0] v);
    if (v == 32'd0) begin
      return OH_ZERO;
    end
    if ((v & (v - 32'd1)) == 32'd0) begin
      return OH_ONE;
    end
    return OH_MULTI;
  endfunction

endpackage

// File: rtl/alu_cmd_driver.sv
// -----------------------------------------------------------------------------
// alu_cmd_driver
// Initiator-side sequencer for the ALU main block. Accepts one command at a
// time over a valid/ready channel, drives the ALU controls, waits the ALU
// result latency, captures the result and returns it over a valid/ready
// response channel. A command may chain on the previous result (num1).
//
// Parameters
//   WIDTH  operand/result width
//   OPW    width of the one-hot operation select
//   LAT    ALU cycles from load to valid alu_out (1..15)
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   on                 enable; low freezes the sequencer and holds the ALU
//   cmd_valid/ready    command handshake
//   cmd_op/a/b/chain   command payload (op all-zero = CLEAR)
//   alu_in_sel         {persist, load, reset} to the ALU
//   alu_num1/num2      ALU operands
//   alu_out_sel        ALU operation select
//   alu_out            ALU result
//   rsp_valid/ready    response handshake
//   rsp_data, rsp_err  captured result, illegal (multi-hot) command flag
//
// Every output is a flop. The combinational process computes the next value
// of each output from the next state, so outputs line up with the state they
// describe. Handshakes are qualified with on, so nothing completes while the
// block is frozen.
// -----------------------------------------------------------------------------
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 6,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_chain,
  output logic [2:0]       alu_in_sel,
  output logic [WIDTH-1:0] alu_num1,
  output logic [WIDTH-1:0] alu_num2,
  output logic [OPW-1:0]   alu_out_sel,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);

  // Counter wide enough for LAT up to 15
  localparam int CNT_W = 4;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] last_res, last_res_d;
  logic             clear_q, clear_d;

  logic             cmd_ready_d;
  logic [2:0]       in_sel_d;
  logic [WIDTH-1:0] num1_d, num2_d, rsp_data_d;
  logic [OPW-1:0]   out_sel_d;
  logic             rsp_valid_d, rsp_err_d;

  logic             cmd_fire, rsp_fire;
  onehot_t          op_kind;

  assign cmd_fire = on && cmd_valid && cmd_ready;
  assign rsp_fire = on && rsp_valid && rsp_ready;
  assign op_kind  = onehot_class(32'(cmd_op));

  // ---------------------------------------------------------------------------
  // Next state, counter, data registers and registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves a
    // value unassigned and no latch is inferred.
    state_d    = state;
    cnt_d      = cnt;
    last_res_d = last_res;
    clear_d    = clear_q;
    num1_d     = alu_num1;
    num2_d     = alu_num2;
    out_sel_d  = alu_out_sel;
    rsp_data_d = rsp_data;
    rsp_err_d  = rsp_err;

    if (on) begin
      unique case (state)
        IDLE: begin
          if (cmd_fire) begin
            if (op_kind == OH_MULTI) begin
              // Illegal select: answer directly, ALU pins stay untouched
              state_d    = RESP;
              rsp_err_d  = 1'b1;
              rsp_data_d = '0;
            end else begin
              state_d   = LOAD;
              clear_d   = (op_kind == OH_ZERO);
              out_sel_d = cmd_op;
              rsp_err_d = 1'b0;
              if (op_kind == OH_ONE) begin
                num1_d = cmd_chain ? last_res : cmd_a;
                num2_d = cmd_b;
              end
            end
          end
        end

        LOAD: begin
          if (clear_q) begin
            state_d    = RESP;
            last_res_d = '0;
            rsp_data_d = '0;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LAT);
          end
        end

        WAIT: begin
          // The ALU latches the operands on the edge that leaves LOAD and its
          // result settles LAT edges later, so it is sampled on the edge after
          // the counter has run down to zero.
          if (cnt == '0) begin
            state_d    = RESP;
            rsp_data_d = alu_out;
            last_res_d = alu_out;
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end

        RESP: begin
          if (rsp_fire) begin
            state_d = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    // Registered outputs follow the state being entered; with on low the
    // state is held and the ALU is parked in HOLD.
    rsp_valid_d = (state_d == RESP);
    cmd_ready_d = on && (state_d == IDLE);
    in_sel_d    = INSEL_HOLD;
    if (on) begin
      unique case (state_d)
        LOAD:    in_sel_d = clear_d ? INSEL_RESET : INSEL_LOAD;
        WAIT:    in_sel_d = INSEL_PERSIST;
        RESP:    in_sel_d = rsp_err_d ? INSEL_HOLD : INSEL_PERSIST;
        default: in_sel_d = INSEL_HOLD;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last_res    <= '0;
      clear_q     <= 1'b0;
      cmd_ready   <= 1'b0;
      alu_in_sel  <= INSEL_HOLD;
      alu_num1    <= '0;
      alu_num2    <= '0;
      alu_out_sel <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      last_res    <= last_res_d;
      clear_q     <= clear_d;
      cmd_ready   <= cmd_ready_d;
      alu_in_sel  <= in_sel_d;
      alu_num1    <= num1_d;
      alu_num2    <= num2_d;
      alu_out_sel <= out_sel_d;
      rsp_valid   <= rsp_valid_d;
      rsp_data    <= rsp_data_d;
      rsp_err     <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_driver
// Bench for alu_cmd_driver with a behavioural ALU whose result appears LAT
// edges after the load edge. Expected responses come from a vector table and
// hand-written sequences, are queued when a command is accepted and compared
// when the response handshake occurs.
// -----------------------------------------------------------------------------
module tb_alu_cmd_driver;
  import alu_pkg::*;

  localparam int LAT = 3;

  typedef struct {
    logic [5:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       chain;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } rsp_t;

  logic       clk = 1'b0;
  logic       rst, on, cmd_valid, cmd_ready, cmd_chain;
  logic [5:0] cmd_op, alu_out_sel;
  logic [7:0] cmd_a, cmd_b, alu_num1, alu_num2, alu_out, rsp_data;
  logic [2:0] alu_in_sel;
  logic       rsp_valid, rsp_ready, rsp_err;

  int         n_cmp  = 0;
  int         n_fail = 0;
  rsp_t       sb[$];
  rsp_t       mon_e;
  logic [7:0] tb_last = 8'h00;
  vec_t       vecs[12];

  always #5 clk = ~clk;

  alu_cmd_driver #(.WIDTH(8), .OPW(6), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .on(on),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
    .alu_in_sel(alu_in_sel), .alu_num1(alu_num1), .alu_num2(alu_num2),
    .alu_out_sel(alu_out_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  // Behavioural ALU: operands latched on a LOAD edge, result visible LAT edges
  // later; HOLD freezes the pipeline, RESET loads zero.
  logic [7:0] pipe [0:LAT];
  initial for (int i = 0; i <= LAT; i++) pipe[i] = 8'h00;
  assign alu_out = pipe[LAT];

  function automatic logic [7:0] alu_f(input logic [7:0] x, input logic [7:0] y,
                                       input logic [5:0] sel);
    case (sel)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_NOT:  return ~x;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_in_sel != INSEL_HOLD) begin
      for (int i = LAT; i > 0; i--) pipe[i] <= pipe[i-1];
      if (alu_in_sel == INSEL_LOAD)       pipe[0] <= alu_f(alu_num1, alu_num2, alu_out_sel);
      else if (alu_in_sel == INSEL_RESET) pipe[0] <= 8'h00;
    end
  end

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: a handshake completes on the next rising edge when all of
  // these hold at the falling edge.
  always @(negedge clk) begin
    if (!rst && on && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 36'd1, 36'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_data", 36'(rsp_data), 36'(mon_e.data));
        check("rsp_err", 36'(rsp_err), 36'(mon_e.err));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits for cmd_ready, presents one command, returns #1 after the accept edge
  task automatic issue(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic chain, input logic [7:0] exp_data, input logic exp_err);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("cmd_ready_wait", 36'(cmd_ready), 36'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    sb.push_back('{exp_data, exp_err});
  endtask

  task automatic run_cmd(input vec_t v);
    int         lat;
    int         exp_lat;
    logic [7:0] n1;
    n1      = v.chain ? tb_last : v.a;
    exp_lat = v.exp_err ? 0 : ((v.op == 6'd0) ? 1 : LAT + 2);
    issue(v.op, v.a, v.b, v.chain, v.exp_data, v.exp_err);
    if (v.exp_err) begin
      check("insel_err", 36'(alu_in_sel), 36'(INSEL_HOLD));
    end else if (v.op == 6'd0) begin
      check("insel_clear", 36'(alu_in_sel), 36'(INSEL_RESET));
    end else begin
      check("insel_load", 36'(alu_in_sel), 36'(INSEL_LOAD));
      check("num1", 36'(alu_num1), 36'(n1));
      check("num2", 36'(alu_num2), 36'(v.b));
      check("out_sel", 36'(alu_out_sel), 36'(v.op));
    end
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
      if (lat == 1 && !v.exp_err && v.op != 6'd0)
        check("insel_persist", 36'(alu_in_sel), 36'(INSEL_PERSIST));
    end
    check("latency", 36'(lat), 36'(exp_lat));
    @(posedge clk); #1;
    check("rsp_valid_drop", 36'(rsp_valid), 36'd0);
    if (!v.exp_err) tb_last = v.exp_data;
  endtask

  initial begin
    int   lat;
    logic seen;

    vecs[0]  = '{OP_ADD,    8'h57, 8'h1A, 1'b0, 8'h71, 1'b0};
    vecs[1]  = '{OP_SUB,    8'hEE, 8'h01, 1'b1, 8'h70, 1'b0};
    vecs[2]  = '{6'b000011, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b1};
    vecs[3]  = '{OP_ADD,    8'hEE, 8'h00, 1'b1, 8'h70, 1'b0};
    vecs[4]  = '{OP_CLEAR,  8'h12, 8'h34, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{OP_OR,     8'hEE, 8'h0F, 1'b1, 8'h0F, 1'b0};
    vecs[6]  = '{OP_AND,    8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0};
    vecs[7]  = '{OP_XOR,    8'hEE, 8'hFF, 1'b1, 8'hCF, 1'b0};
    vecs[8]  = '{OP_NOT,    8'h55, 8'h00, 1'b0, 8'hAA, 1'b0};
    vecs[9]  = '{6'b100001, 8'h11, 8'h22, 1'b0, 8'h00, 1'b1};
    vecs[10] = '{OP_ADD,    8'hFF, 8'h02, 1'b0, 8'h01, 1'b0};
    vecs[11] = '{OP_SUB,    8'hEE, 8'h02, 1'b1, 8'hFF, 1'b0};

    rst = 1'b1; on = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0;
    cmd_b = '0; cmd_chain = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 36'({cmd_ready, alu_in_sel, rsp_valid, rsp_err}), 36'd0);
    check("reset_data", 36'({alu_num1, alu_num2, alu_out_sel, rsp_data}), 36'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_cmd(vecs[i]);

    // Enable dropped for three edges inside WAIT, then a stalled response
    rsp_ready = 1'b0;
    issue(OP_ADD, 8'h20, 8'h22, 1'b0, 8'h42, 1'b0);
    lat = 0;
    while (!rsp_valid && lat < 60) begin
      @(posedge clk); #1; lat++;
      if (lat == 2) on = 1'b0;
      if (lat >= 3 && lat <= 5) check("insel_frozen", 36'(alu_in_sel), 36'(INSEL_HOLD));
      if (lat == 5) on = 1'b1;
    end
    check("latency_freeze", 36'(lat), 36'(LAT + 2 + 3));
    repeat (5) begin
      @(posedge clk); #1;
      check("rsp_hold_valid", 36'(rsp_valid), 36'd1);
      check("rsp_hold_data", 36'(rsp_data), 36'h42);
    end
    on = 1'b0; rsp_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("rsp_off_valid", 36'(rsp_valid), 36'd1);
      check("cmd_ready_off", 36'(cmd_ready), 36'd0);
    end
    on = 1'b1;
    @(posedge clk); #1;
    check("rsp_resume_drop", 36'(rsp_valid), 36'd0);
    tb_last = 8'h42;

    // Reset in the middle of WAIT abandons the command
    issue(OP_ADD, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_mid_ctrl", 36'({cmd_ready, alu_in_sel, rsp_valid, rsp_err}), 36'd0);
    check("rst_mid_data", 36'({alu_num1, alu_num2, alu_out_sel, rsp_data}), 36'd0);
    sb.delete();
    tb_last = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    check("no_rsp_after_rst", 36'(seen), 36'd0);
    run_cmd('{OP_ADD, 8'hEE, 8'h05, 1'b1, 8'h05, 1'b0});

    check("sb_empty", 36'(sb.size()), 36'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
